// File: rtl/cacheline_adaptor_pkg.sv
// Shared definitions for the cache-line / memory-burst adaptor.
//   LINE_W   : cache line width in bits
//   BURST_W  : memory beat width in bits
//   BEATS    : beats per cache line
//   state_t  : adaptor FSM state
package cacheline_adaptor_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned BURST_W  = 64;
    localparam int unsigned BEATS    = LINE_W / BURST_W;
    localparam int unsigned CNT_W    = $clog2(BEATS);

    // Low address bits dropped when aligning to a line boundary.
    localparam logic [31:0] LINE_MASK = ~32'(LINE_W / 8 - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bit offset of beat slot idx inside the line buffer.
    function automatic int unsigned slot_lo(input logic [CNT_W-1:0] idx);
        return 32'(idx) * BURST_W;
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts single-cycle cache line requests into 4-beat memory bursts.
//   clk, rst           : clock, synchronous active-high reset
//   line_i / line_o    : write-back line in / assembled fill line out
//   address_i          : cache line address (aligned internally)
//   read_i / write_i   : cache requests, held until resp_o
//   resp_o             : one-cycle completion pulse to the cache
//   burst_i / burst_o  : memory read beat in / memory write beat out
//   address_o          : line-aligned address to memory
//   read_o / write_o   : memory burst requests
//   resp_i             : memory beat strobe, one beat per high cycle
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    state_t             state;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   next_cnt;
    logic               last_beat;
    logic [LINE_W-1:0]  line_buf;
    logic [31:0]        addr_reg;
    logic [BURST_W-1:0] burst_reg;

    assign next_cnt  = beat_cnt + CNT_W'(1);
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            line_buf  <= '0;
            addr_reg  <= '0;
            burst_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Write-back has priority over fill.
                    if (write_i) begin
                        line_buf  <= line_i;
                        addr_reg  <= address_i & LINE_MASK;
                        beat_cnt  <= '0;
                        burst_reg <= line_i[BURST_W-1:0];
                        state     <= WR;
                    end else if (read_i) begin
                        addr_reg  <= address_i & LINE_MASK;
                        beat_cnt  <= '0;
                        state     <= RD;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        line_buf[slot_lo(beat_cnt) +: BURST_W] <= burst_i;
                        beat_cnt <= next_cnt;
                        if (last_beat) state <= DONE;
                    end
                end
                WR: begin
                    // burst_o is registered so it keeps the last beat after
                    // the burst; it is preloaded one slot ahead on each ack.
                    if (resp_i) begin
                        beat_cnt <= next_cnt;
                        if (last_beat) state <= DONE;
                        else burst_reg <= line_buf[slot_lo(next_cnt) +: BURST_W];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign read_o    = (state == RD);
    assign write_o   = (state == WR);
    assign resp_o    = (state == DONE);
    assign address_o = addr_reg;
    assign burst_o   = burst_reg;
    assign line_o    = line_buf;

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 The module SHALL have no parameters; widths SHALL come from the shared package: LINE_W 256 (cache line bits), BURST_W 64 (memory beat bits), BEATS 4 (beats per line).
REQ-002 The module SHALL use one clock and a synchronous, active-high reset.
REQ-003 The ports SHALL be:
  clk  in  1  clock; all state changes on its rising edge.
  rst  in  1  synchronous, active-high reset.
  line_i  in  256  write-back line from the cache.
  line_o  out  256  assembled fill line to the cache.
  address_i  in  32  cache line address.
  read_i  in  1  cache fill request, held until resp_o.
  write_i  in  1  cache write-back request, held until resp_o.
  resp_o  out  1  one-cycle completion pulse to the cache.
  burst_i  in  64  memory read beat.
  burst_o  out  64  memory write beat.
  address_o  out  32  line-aligned address to memory.
  read_o  out  1  memory burst read request.
  write_o  out  1  memory burst write request.
  resp_i  in  1  memory beat strobe, one beat per high cycle.

Function
REQ-004 The FSM SHALL have states IDLE, RD, WR and DONE.
REQ-005 In IDLE with write_i=1: latch line_i into the line buffer and {address_i[31:5],5'b0} into the address register, clear beat_cnt, then go to WR.
REQ-006 In IDLE with read_i=1 and write_i=0: latch the aligned address, clear beat_cnt, then go to RD.
REQ-007 When read_i and write_i are both high in IDLE, write SHALL win.
REQ-008 In RD: read_o=1 and address_o=latched address; each cycle with resp_i=1 SHALL store burst_i into buffer bits [64*beat_cnt+63 : 64*beat_cnt] and increment beat_cnt.
REQ-009 RD SHALL go to DONE on the cycle the 4th beat (beat_cnt=3 with resp_i=1) is captured.
REQ-010 In WR: write_o=1, address_o=latched address, burst_o=buffer slot beat_cnt; each cycle with resp_i=1 SHALL advance beat_cnt.
REQ-011 WR SHALL go to DONE when the 4th beat is acknowledged.
REQ-012 Beats need not be consecutive; resp_i=0 cycles SHALL hold beat_cnt and the buffer.
REQ-013 In DONE: resp_o=1 for exactly one cycle, read_o=write_o=0, then go to IDLE.
REQ-014 line_o SHALL always drive the line buffer; after a read it SHALL be valid in the DONE cycle and held until the next request is latched.
REQ-015 read_o, write_o and resp_o SHALL be 0 in every state other than the one that asserts them; address_o and burst_o SHALL hold their last value when unused.
REQ-016 resp_i SHALL be ignored in IDLE and DONE.
REQ-017 read_i and write_i SHALL be ignored outside IDLE.
REQ-018 beat_cnt SHALL be 2 bits and wrap to 0 after the 4th beat.
REQ-019 Minimum latency: request seen at cycle T; read_o/write_o high from T+1; with resp_i high at T+1..T+4, resp_o=1 at T+5.

Reset
REQ-020 With rst=1 at a clock edge: state=IDLE, beat_cnt=0, line buffer=0, address register=0; read_o, write_o and resp_o SHALL be 0 in the following cycle.
REQ-021 Reset SHALL abort any in-flight RD or WR without issuing resp_o; memory beats that arrive after reset SHALL be ignored.

Structure
REQ-022 The shared package SHALL hold LINE_W, BURST_W, BEATS and the adaptor state enum.
REQ-023 The block SHALL be a single module with no sub-modules.

Verification
REQ-024 Read fill: read_i=1, address_i=0x0000_1234; burst_i=0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i cycles -> address_o=0x0000_1220, resp_o one cycle after the 4th beat, line_o={0x44..,0x33..,0x22..,0x11..}.
REQ-025 Write-back: write_i=1, line_i={0xD..,0xC..,0xB..,0xA..} -> burst_o=0xA..,0xB..,0xC..,0xD.. on successive acknowledged beats, write_o falls after the 4th beat, resp_o=1 once.
REQ-026 Stalled beats: resp_i pattern 1,0,0,1,1,0,1 during RD -> 4 beats captured in order, resp_o only after the 7th cycle.
REQ-027 Simultaneous request: read_i=write_i=1 in IDLE -> write_o asserted, read_o stays 0.
REQ-028 Reset mid-read after 2 beats -> next cycle state IDLE, read_o=0, resp_o never pulses; a new read then completes normally.
REQ-029 Back-to-back: dirty miss sequence (write then read, the cache dropping write_i after resp_o) -> two resp_o pulses, and the read line is correct.
